mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage initiator for the word-wide data memory (1-cycle comb read, posedge write).
//  Turns pipeline loads/stores (lb/lbu/lh/lhu/lw/sb/sh/sw) into word accesses.
//  Sub-word stores run a 2-cycle read-modify-write that stalls the pipeline.
//  Loads are extracted and extended combinationally. Misaligned or conflicting requests are flagged.
// PARAMETERS
//  ADDR_W   32  byte-address width on both the pipeline side and the memory side
//  BIG_END  0   0: byte 0 = bits[7:0] (little-endian lanes); 1: byte 0 = bits[31:24]
// PORTS
//  clk            in   1       single clock, all state on posedge
//  rst_n          in   1       asynchronous active-low reset
//  MemRead_i      in   1       load request (held by the pipeline while stall_o=1)
//  MemWrite_i     in   1       store request (held by the pipeline while stall_o=1)
//  size_i         in   2       00 byte, 01 half, 10 word, 11 reserved
//  unsigned_i     in   1       1: zero-extend loads; 0: sign-extend loads
//  addr_i         in   ADDR_W  byte address
//  store_data_i   in   32      store data, right-justified
//  dm_read_o      out  1       memory MemRead
//  dm_write_o     out  1       memory MemWrite
//  dm_addr_o      out  ADDR_W  memory address, word aligned ([1:0]=00)
//  dm_wdata_o     out  32      memory write data
//  dm_rdata_i     in   32      memory read data (combinational)
//  load_data_o    out  32      extracted and extended load result
//  stall_o        out  1       1: hold the pipeline this cycle
//  access_err_o   out  1       1: request rejected (misaligned, size 11, or read+write)
// BEHAVIOUR
//  State machine IDLE/RMW_WR, 1 bit. Internal registers: rmw_addr, rmw_word (32 bits).
//  Reset: state=IDLE, rmw_* = 0. With no request, every output is 0.
//  err = (MemRead_i|MemWrite_i) & (size 11 | (half & addr[0]) | (word & addr[1:0]!=0) | (MemRead_i&MemWrite_i)).
//   - On err: no dm_read/dm_write, access_err_o=1 comb, stall_o=0, load_data_o=0.
//  Load (IDLE, no err): dm_read_o=1, dm_addr_o={addr[ADDR_W-1:2],2'b00}.
//   - Extract the lane from addr[1:0]; extend per unsigned_i. 0 added latency, no stall.
//  Word store (IDLE, no err): dm_write_o=1, dm_wdata_o=store_data_i. Committed at this posedge, no stall.
//  Sub-word store, cycle 1 (IDLE): dm_read_o=1, stall_o=1.
//   - Merge: replace lane(s) selected by addr[1:0] in dm_rdata_i with store_data_i[7:0]/[15:0].
//   - Register merged word into rmw_word and the aligned address into rmw_addr; go to RMW_WR.
//  Sub-word store, cycle 2 (RMW_WR): dm_write_o=1, dm_addr_o=rmw_addr, dm_wdata_o=rmw_word, stall_o=0.
//   - Request inputs ignored; go to IDLE. Pipeline advances at the end of this cycle.
//  Back-to-back: a new request in the cycle after RMW_WR is served normally.
//   - A load right after an RMW to the same word sees the new data (write lands at the RMW_WR edge).
//  Reset asserted mid-RMW: return to IDLE at once; the pending write is dropped; memory keeps its old word.
//  stall_o is never high for more than 1 consecutive cycle. dm_read_o and dm_write_o are never both 1.
//  Memory-side address always has [1:0]=00. Bits above the memory depth pass through unchanged.
// STRUCTURE
//  Shared package mem_pkg: SIZE_B/SIZE_H/SIZE_W encodings, state enum {IDLE,RMW_WR}, lane-mask function.
//  One sub-module: mem_lane_align. Combinational lane extract/extend for loads and lane merge for stores.
//   - Shared by both paths and unit-tested alone.
//  Top level: FSM, rmw registers, error decode, output muxing.
// TESTING (bench models the data memory: 256 words, comb read, posedge write)
//  1 lb/lbu: mem[1]=0x80FF_7F01, addr=0x6 -> lb=0xFFFF_FFFF? no: byte2=0xFF -> lb 0xFFFF_FFFF, lbu 0x0000_00FF, stall 0.
//  2 sh: mem[2]=0xAABB_CCDD, addr=0xA, data=0x1234 -> stall 1 cycle, then write 0x1234_CCDD to word 2.
//  3 sb x4 back-to-back: sb 0x11..0x44 to addr 0x10..0x13 on 0 -> mem[4]=0x4433_2211, 4 stalls, 8 cycles total.
//  4 Errors: lw addr 0x3, lh addr 0x1, size 11, read+write -> access_err_o=1, no dm strobes, mem unchanged.
//  5 Reset mid-RMW: sb then rst_n=0 in RMW_WR -> no write, outputs 0, next lw returns the old word.
//  6 sw addr 0x20 data 0xDEAD_BEEF then lw addr 0x20 -> 0xDEAD_BEEF, stall never asserted.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
//   SIZE_*      : pipeline access-size encodings (byte / half / word / reserved)
//   mau_state_e : access FSM states (IDLE, RMW_WR)
//   lane_mask   : byte-lane enable mask for an access of a given size/offset
//   lane_shift  : bit position of the lowest bit of the addressed lane(s)
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_R = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } mau_state_e;

  // Byte lanes touched by an access. For big-endian, byte 0 sits in the
  // top lane, so the lane index is mirrored.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] off,
                                           input logic       big_end);
    logic [1:0] lane;
    lane = big_end ? (2'd3 - off) : off;
    case (size)
      SIZE_B:  lane_mask = 4'b0001 << lane;
      SIZE_H:  lane_mask = (off[1] ^ big_end) ? 4'b1100 : 4'b0011;
      SIZE_W:  lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Right-shift amount that brings the addressed lane(s) down to bit 0.
  function automatic logic [4:0] lane_shift(input logic [1:0] size,
                                            input logic [1:0] off,
                                            input logic       big_end);
    logic [1:0] lane;
    lane = big_end ? (2'd3 - off) : off;
    case (size)
      SIZE_B:  lane_shift = {lane, 3'b000};
      SIZE_H:  lane_shift = (off[1] ^ big_end) ? 5'd16 : 5'd0;
      SIZE_W:  lane_shift = 5'd0;
      default: lane_shift = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering between a 32-bit memory word and the pipeline.
//   size_i, offset_i : access size and byte offset within the word
//   unsigned_i       : 1 zero-extends loads, 0 sign-extends
//   rdata_i          : word read from memory
//   store_data_i     : right-justified store data
//   load_data_o      : extracted and extended load value
//   merged_o         : rdata_i with the addressed lane(s) replaced by store data
module mem_lane_align
  import mem_pkg::*;
#(
  parameter bit BIG_END = 1'b0
) (
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        unsigned_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [31:0] shifted_s;
  logic [31:0] repl_s;
  logic [3:0]  mask_s;

  // Load path: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted_s = rdata_i >> lane_shift(size_i, offset_i, BIG_END);
    case (size_i)
      SIZE_B:  load_data_o = {{24{~unsigned_i & shifted_s[7]}}, shifted_s[7:0]};
      SIZE_H:  load_data_o = {{16{~unsigned_i & shifted_s[15]}}, shifted_s[15:0]};
      SIZE_W:  load_data_o = rdata_i;
      default: load_data_o = 32'h0000_0000;
    endcase
  end

  // Store path: replicate the store data into every lane so the lane mask
  // alone decides which bytes of the old word are replaced.
  always_comb begin
    mask_s = lane_mask(size_i, offset_i, BIG_END);
    case (size_i)
      SIZE_B:  repl_s = {4{store_data_i[7:0]}};
      SIZE_H:  repl_s = {2{store_data_i[15:0]}};
      SIZE_W:  repl_s = store_data_i;
      default: repl_s = rdata_i;
    endcase
    merged_o = rdata_i;
    for (int i = 0; i < 4; i++) begin
      if (mask_s[i]) begin
        merged_o[i*8 +: 8] = repl_s[i*8 +: 8];
      end else begin
        merged_o[i*8 +: 8] = rdata_i[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-wide data memory (combinational read,
// posedge write). Loads and word stores complete in one cycle; byte and
// half stores run a two-cycle read-modify-write that stalls once.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   MemRead_i, MemWrite_i      : load / store request from the pipeline
//   size_i, unsigned_i         : access size, load extension mode
//   addr_i, store_data_i       : byte address, right-justified store data
//   dm_read_o, dm_write_o      : memory strobes
//   dm_addr_o, dm_wdata_o      : word-aligned memory address, write data
//   dm_rdata_i                 : memory read data
//   load_data_o                : load result
//   stall_o                    : hold the pipeline this cycle
//   access_err_o               : request rejected
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter bit BIG_END = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       store_data_i,
  output logic              dm_read_o,
  output logic              dm_write_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [31:0]       dm_wdata_o,
  input  logic [31:0]       dm_rdata_i,
  output logic [31:0]       load_data_o,
  output logic              stall_o,
  output logic              access_err_o
);

  mau_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
  logic [31:0]       rmw_word_q, rmw_word_d;

  logic              req_s;
  logic              err_s;
  logic              sub_store_s;
  logic [ADDR_W-1:0] aligned_addr_s;
  logic [31:0]       lane_load_s;
  logic [31:0]       lane_merge_s;

  mem_lane_align #(
    .BIG_END (BIG_END)
  ) u_align (
    .size_i       (size_i),
    .offset_i     (addr_i[1:0]),
    .unsigned_i   (unsigned_i),
    .rdata_i      (dm_rdata_i),
    .store_data_i (store_data_i),
    .load_data_o  (lane_load_s),
    .merged_o     (lane_merge_s)
  );

  // Request decode: alignment / size / read+write conflict checks.
  always_comb begin
    req_s          = MemRead_i | MemWrite_i;
    aligned_addr_s = {addr_i[ADDR_W-1:2], 2'b00};
    err_s          = req_s & ((size_i == SIZE_R)
                            | ((size_i == SIZE_H) & addr_i[0])
                            | ((size_i == SIZE_W) & (addr_i[1:0] != 2'b00))
                            | (MemRead_i & MemWrite_i));
    // A conflicting read+write is already an error, so this is a pure store.
    sub_store_s    = MemWrite_i & ~err_s & (size_i != SIZE_W);
  end

  // State and read-modify-write holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rmw_addr_q <= {ADDR_W{1'b0}};
      rmw_word_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      rmw_addr_q <= rmw_addr_d;
      rmw_word_q <= rmw_word_d;
    end
  end

  // Next state: a sub-word store captures the merged word and spends one
  // extra cycle writing it back; the request inputs are ignored meanwhile.
  always_comb begin
    state_d    = state_q;
    rmw_addr_d = rmw_addr_q;
    rmw_word_d = rmw_word_q;
    case (state_q)
      IDLE: begin
        if (sub_store_s) begin
          state_d    = RMW_WR;
          rmw_addr_d = aligned_addr_s;
          rmw_word_d = lane_merge_s;
        end else begin
          state_d    = IDLE;
        end
      end
      RMW_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: everything is zero unless a valid request or the write-back
  // cycle drives it.
  always_comb begin
    dm_read_o    = 1'b0;
    dm_write_o   = 1'b0;
    dm_addr_o    = {ADDR_W{1'b0}};
    dm_wdata_o   = 32'h0000_0000;
    load_data_o  = 32'h0000_0000;
    stall_o      = 1'b0;
    access_err_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (err_s) begin
          access_err_o = 1'b1;
        end else if (MemRead_i) begin
          dm_read_o   = 1'b1;
          dm_addr_o   = aligned_addr_s;
          load_data_o = lane_load_s;
        end else if (MemWrite_i && (size_i == SIZE_W)) begin
          dm_write_o  = 1'b1;
          dm_addr_o   = aligned_addr_s;
          dm_wdata_o  = store_data_i;
        end else if (sub_store_s) begin
          dm_read_o   = 1'b1;
          dm_addr_o   = aligned_addr_s;
          stall_o     = 1'b1;
        end else begin
          dm_read_o   = 1'b0;
        end
      end
      RMW_WR: begin
        dm_write_o = 1'b1;
        dm_addr_o  = rmw_addr_q;
        dm_wdata_o = rmw_word_q;
      end
      default: begin
        dm_read_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the stimulus thread computes each
// expected memory-side response from a word-array reference model and queues
// it; a monitor thread pops and compares whenever the DUT presents a response.
module tb_mem_access_unit;

  localparam int         ADDR_W  = 32;
  localparam logic [1:0] K_LOAD  = 2'd0;
  localparam logic [1:0] K_WRITE = 2'd1;
  localparam logic [1:0] K_ERR   = 2'd2;
  localparam logic [1:0] K_NONE  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              MemRead_i, MemWrite_i, unsigned_i;
  logic [1:0]        size_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       store_data_i;
  logic              dm_read_o, dm_write_o, stall_o, access_err_o;
  logic [ADDR_W-1:0] dm_addr_o;
  logic [31:0]       dm_wdata_o, dm_rdata_i, load_data_o;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  mem_access_unit #(.ADDR_W(ADDR_W), .BIG_END(1'b0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .size_i       (size_i),
    .unsigned_i   (unsigned_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .dm_read_o    (dm_read_o),
    .dm_write_o   (dm_write_o),
    .dm_addr_o    (dm_addr_o),
    .dm_wdata_o   (dm_wdata_o),
    .dm_rdata_i   (dm_rdata_i),
    .load_data_o  (load_data_o),
    .stall_o      (stall_o),
    .access_err_o (access_err_o)
  );

  always #5 clk = ~clk;

  assign dm_rdata_i = mem[dm_addr_o[9:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic ref_err(input logic rd, input logic wr, input logic [1:0] sz,
                                   input logic [31:0] a);
    if (!(rd || wr)) return 1'b0;
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (rd && wr);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] off);
    logic [31:0] v;
    v = word >> (off * 8);
    if (sz == 2'd0) begin
      v = v & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] sz,
                                            input logic [1:0] off, input logic [31:0] d);
    logic [31:0] m;
    if (sz == 2'd2) return d;
    m = (sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
    return (old & ~(m << (off * 8))) | ((d & m) << (off * 8));
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    MemRead_i = rd; MemWrite_i = wr; size_i = sz; unsigned_i = uns;
    addr_i = a; store_data_i = d;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic preload(input int w, input logic [31:0] v);
    mem[w] = v;
    ref_mem[w] = v;
  endtask

  // One pipeline request, held while the DUT stalls. Returns cycles spent
  // and stall cycles seen.
  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] d,
                    output int cycles, output int stalls);
    exp_t        e;
    int          w;
    logic        s;
    logic [31:0] nw;
    w = int'(a[9:2]);
    if (ref_err(rd, wr, sz, a)) begin
      e = '{kind: K_ERR, addr: 32'h0, data: 32'h0};
    end else if (rd) begin
      e = '{kind: K_LOAD, addr: {a[31:2], 2'b00}, data: ref_load(ref_mem[w], sz, uns, a[1:0])};
    end else begin
      nw = ref_store(ref_mem[w], sz, a[1:0], d);
      ref_mem[w] = nw;
      e = '{kind: K_WRITE, addr: {a[31:2], 2'b00}, data: nw};
    end
    if (rd || wr) exp_q.push_back(e);
    drive(rd, wr, sz, uns, a, d);
    cycles = 0;
    stalls = 0;
    do begin
      @(negedge clk);
      s = stall_o;
      @(posedge clk); #1;
      cycles++;
      if (s) stalls++;
    end while (s && cycles < 4);
    if (s) check("stall_bound", {31'b0, s}, 32'h0);
  endtask

  // ---------------- monitor / memory / watchdog threads ----------------
  task automatic pop_exp(output exp_t e);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_response: got a response with empty queue at %0t", $time);
      e = '{kind: K_NONE, addr: 32'h0, data: 32'h0};
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    logic prev_stall;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_o) check("stall_run", {31'b0, prev_stall}, 32'h0);
      prev_stall = stall_o;
      if (access_err_o) begin
        pop_exp(e);
        check("kind_err", {30'b0, e.kind}, {30'b0, K_ERR});
        check("err_strobes", {29'b0, dm_read_o, dm_write_o, stall_o}, 32'h0);
        check("err_load", load_data_o, 32'h0);
      end else if (dm_write_o) begin
        pop_exp(e);
        check("kind_write", {30'b0, e.kind}, {30'b0, K_WRITE});
        check("wr_addr", dm_addr_o, e.addr);
        check("wr_data", dm_wdata_o, e.data);
        check("wr_side", {30'b0, dm_read_o, stall_o}, 32'h0);
      end else if (dm_read_o && !stall_o) begin
        pop_exp(e);
        check("kind_load", {30'b0, e.kind}, {30'b0, K_LOAD});
        check("ld_addr", dm_addr_o, e.addr);
        check("ld_data", load_data_o, e.data);
      end else if (stall_o) begin
        check("rmw_rd", {30'b0, dm_read_o, (dm_addr_o[1:0] != 2'b00)}, 32'h2);
      end else if (!MemRead_i && !MemWrite_i) begin
        check("idle_outs", load_data_o | dm_addr_o | dm_wdata_o, 32'h0);
      end else begin
        check("no_response", {29'b0, dm_read_o, dm_write_o, access_err_o}, 32'h7);
      end
    end
  endtask

  task automatic mem_loop();
    forever begin
      @(posedge clk);
      if (dm_write_o) mem[dm_addr_o[9:2]] <= dm_wdata_o;
    end
  endtask

  task automatic watchdog();
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c, s, tc, ts;
    int unsigned r;
    logic rd, wr, uns;
    logic [1:0] sz;
    logic [31:0] a;

    for (int i = 0; i < 256; i++) preload(i, 32'h0);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    fork
      monitor_loop();
      mem_loop();
      watchdog();
    join_none

    @(negedge clk);
    check("reset_outs", {28'b0, dm_read_o, dm_write_o, stall_o, access_err_o}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // 1: lb / lbu of byte 2 of 0x80FF_7F01
    preload(1, 32'h80FF_7F01);
    op(1'b1, 1'b0, 2'd0, 1'b0, 32'h6, 32'h0, c, s);
    op(1'b1, 1'b0, 2'd0, 1'b1, 32'h6, 32'h0, c, s);
    check("lbu_stall", s, 0);
    op(1'b1, 1'b0, 2'd1, 1'b0, 32'h2, 32'h0, c, s);

    // 2: sh into upper half of word 2
    preload(2, 32'hAABB_CCDD);
    op(1'b0, 1'b1, 2'd1, 1'b0, 32'hA, 32'h0000_1234, c, s);
    check("sh_stalls", s, 1);
    idle(1);
    check("mem2", mem[2], 32'h1234_CCDD);

    // 3: four back-to-back sb into word 4
    tc = 0; ts = 0;
    for (int i = 0; i < 4; i++) begin
      op(1'b0, 1'b1, 2'd0, 1'b0, 32'h10 + i, 32'h11 * (i + 1), c, s);
      tc += c; ts += s;
    end
    idle(1);
    check("sb4_cycles", tc, 8);
    check("sb4_stalls", ts, 4);
    check("mem4", mem[4], 32'h4433_2211);
    op(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, c, s);

    // 4: rejected requests leave memory untouched
    preload(0, 32'h0102_0304);
    op(1'b1, 1'b0, 2'd2, 1'b0, 32'h3, 32'h0, c, s);
    op(1'b1, 1'b0, 2'd1, 1'b0, 32'h1, 32'h0, c, s);
    op(1'b0, 1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFF_FFFF, c, s);
    op(1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF, c, s);
    op(1'b0, 1'b1, 2'd1, 1'b0, 32'h3, 32'hFFFF_FFFF, c, s);
    idle(1);
    check("mem0_kept", mem[0], 32'h0102_0304);

    // 6: sw then lw, no stall
    op(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, c, s);
    check("sw_stalls", s, 0);
    op(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, c, s);
    check("lw_stalls", s, 0);
    check("mem8", mem[8], 32'hDEAD_BEEF);

    // 5: reset during the write-back cycle drops the write
    preload(12, 32'hCAFE_F00D);
    drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h31, 32'h0000_005A);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rst_outs", {28'b0, dm_read_o, dm_write_o, stall_o, access_err_o}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mem12_kept", mem[12], 32'hCAFE_F00D);
    op(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, c, s);

    // Randomised traffic on words 16..31
    for (int i = 16; i < 32; i++) preload(i, $urandom);
    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 9);
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      r  = $urandom_range(0, 7);
      sz = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
      uns = 1'($urandom_range(0, 1));
      a  = 32'h40 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      op(rd, wr, sz, uns, a, $urandom, c, s);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);
    for (int i = 16; i < 32; i++) check("final_mem", mem[i], ref_mem[i]);

    idle(3);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
